// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one DRAM command port between an instruction-cache read
// port, a data-cache read port and a two-beat write port. Reads are tagged in
// issue order so the two-beat read returns can be steered back to the owner.
//
// Handshake: ic_req/dc_req/wr_req are level requests held (with address/data)
// until the matching one-cycle gnt pulse; a FIFO push happens on any cycle its
// wr_en is high, and wr_en is never raised while that FIFO reports full.
module mem_arbiter #(
  parameter int TAG_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ic_req,
  input  logic         dc_req,
  input  logic [30:0]  ic_addr,
  input  logic [30:0]  dc_addr,
  output logic         ic_gnt,
  output logic         dc_gnt,
  output logic         ic_rvalid,
  output logic         dc_rvalid,
  output logic [127:0] rdata,
  input  logic         wr_req,
  input  logic [30:0]  wr_addr,
  input  logic [255:0] wr_data,
  input  logic [31:0]  wr_mask,
  output logic         wr_gnt,
  input  logic         af_full,
  output logic [30:0]  af_addr_din,
  output logic [2:0]   af_cmd_din,
  output logic         af_wr_en,
  input  logic         wdf_full,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din,
  output logic         wdf_wr_en,
  input  logic         rdf_valid,
  input  logic [127:0] rdf_dout,
  output logic         err,
  output logic [1:0]   state_dbg
);

  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = TAG_DEPTH[PW:0];

  // Requester IDs; also the round-robin pointer encoding.
  localparam logic [1:0] ID_IC = 2'd0;
  localparam logic [1:0] ID_DC = 2'd1;
  localparam logic [1:0] ID_WR = 2'd2;

  typedef enum logic [1:0] {IDLE, RD, WR1, WR2} state_t;

  state_t          state, state_nxt;
  logic [1:0]      win, win_nxt;
  logic [1:0]      rr_last;
  logic            pick_valid;
  logic [1:0]      pick;
  logic            push;

  logic [TAG_DEPTH-1:0] tag_mem;   // owner bit per outstanding read: 0 ic, 1 dc
  logic [PW-1:0]   tag_wp, tag_rp;
  logic [PW:0]     tag_cnt;
  logic            tag_full, tag_empty;
  logic            beat;           // 0 = first return beat, 1 = second
  logic            ret_beat, pop, owner;
  logic            ic_ok, dc_ok;

  assign tag_full  = (tag_cnt == FULL_CNT);
  assign tag_empty = (tag_cnt == '0);
  assign ic_ok     = ic_req && !tag_full;
  assign dc_ok     = dc_req && !tag_full;
  assign state_dbg = state;
  assign rdata     = rdf_dout;

  // Read-return steering: the tag FIFO head owns every beat on the bus.
  assign owner     = tag_mem[tag_rp];
  assign ret_beat  = rdf_valid && !tag_empty;
  assign ic_rvalid = ret_beat && !owner;
  assign dc_rvalid = ret_beat && owner;
  assign pop       = ret_beat && beat;

  // Round-robin pick, searching from the requester after the last granted one.
  always_comb begin
    pick_valid = 1'b1;
    pick       = ID_IC;
    case (rr_last)
      ID_IC: begin
        if (dc_ok)       pick = ID_DC;
        else if (wr_req) pick = ID_WR;
        else if (ic_ok)  pick = ID_IC;
        else             pick_valid = 1'b0;
      end
      ID_DC: begin
        if (wr_req)      pick = ID_WR;
        else if (ic_ok)  pick = ID_IC;
        else if (dc_ok)  pick = ID_DC;
        else             pick_valid = 1'b0;
      end
      default: begin
        if (ic_ok)       pick = ID_IC;
        else if (dc_ok)  pick = ID_DC;
        else if (wr_req) pick = ID_WR;
        else             pick_valid = 1'b0;
      end
    endcase
  end

  // Next-state and command/grant outputs for the current transaction.
  always_comb begin
    state_nxt    = state;
    win_nxt      = win;
    ic_gnt       = 1'b0;
    dc_gnt       = 1'b0;
    wr_gnt       = 1'b0;
    af_wr_en     = 1'b0;
    wdf_wr_en    = 1'b0;
    push         = 1'b0;
    af_cmd_din   = 3'b000;
    af_addr_din  = (win == ID_IC) ? ic_addr : ((win == ID_DC) ? dc_addr : wr_addr);
    wdf_din      = wr_data[255:128];
    wdf_mask_din = wr_mask[31:16];
    case (state)
      IDLE: begin
        if (pick_valid) begin
          win_nxt   = pick;
          state_nxt = (pick == ID_WR) ? WR1 : RD;
        end
      end
      RD: begin
        af_cmd_din = 3'b001;
        af_wr_en   = !af_full;
        if (!af_full) begin
          ic_gnt    = (win == ID_IC);
          dc_gnt    = (win == ID_DC);
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      WR1: begin
        af_wr_en  = !af_full && !wdf_full;
        wdf_wr_en = !af_full && !wdf_full;
        if (!af_full && !wdf_full) state_nxt = WR2;
      end
      WR2: begin
        wdf_din      = wr_data[127:0];
        wdf_mask_din = wr_mask[15:0];
        wdf_wr_en    = !wdf_full;
        if (!wdf_full) begin
          wr_gnt    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, latched winner and round-robin pointer (moves only on a grant).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      win     <= ID_IC;
      rr_last <= ID_WR;
    end else begin
      state <= state_nxt;
      win   <= win_nxt;
      if (ic_gnt || dc_gnt || wr_gnt) rr_last <= win;
    end
  end

  // Tag FIFO, return-beat counter and sticky orphan-data error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_mem <= '0;
      tag_wp  <= '0;
      tag_rp  <= '0;
      tag_cnt <= '0;
      beat    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (push) begin
        tag_mem[tag_wp] <= win[0];
        tag_wp          <= tag_wp + 1'b1;
      end
      if (pop) tag_rp <= tag_rp + 1'b1;
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
      if (ret_beat) beat <= ~beat;
      if (rdf_valid && tag_empty) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios against a transaction-level model of the
// arbiter, compared on every falling edge, plus literal spot checks.
module tb_mem_arbiter;

  localparam int TAG_DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_req, dc_req, wr_req;
  logic [30:0]  ic_addr, dc_addr, wr_addr;
  logic [255:0] wr_data;
  logic [31:0]  wr_mask;
  logic         af_full, wdf_full, rdf_valid;
  logic [127:0] rdf_dout;
  logic         ic_gnt, dc_gnt, wr_gnt, ic_rvalid, dc_rvalid, err;
  logic         af_wr_en, wdf_wr_en;
  logic [127:0] rdata, wdf_din;
  logic [30:0]  af_addr_din;
  logic [2:0]   af_cmd_din;
  logic [15:0]  wdf_mask_din;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_err    = 0;

  // Transaction-level model: current transaction, round-robin memory,
  // outstanding-read owner queue.
  int m_who   = -1;   // -1 none, 0 ic read, 1 dc read, 2 write
  int m_beat  = 0;    // write beat index
  int m_last  = 2;    // last granted requester
  int m_tagq[$];
  int m_beats = 0;
  bit m_err   = 0;

  int glog[$];        // grants seen on the DUT, in order
  int blog[$];        // return-beat owners seen on the DUT, in order

  localparam logic [127:0] T3_HI = 128'hfedcba98_76543210_0f1e2d3c_4b5a6978;
  localparam logic [127:0] T3_LO = 128'h01234567_89abcdef_13579bdf_2468ace0;

  mem_arbiter #(.TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .dc_req(dc_req), .ic_addr(ic_addr), .dc_addr(dc_addr),
    .ic_gnt(ic_gnt), .dc_gnt(dc_gnt), .ic_rvalid(ic_rvalid), .dc_rvalid(dc_rvalid),
    .rdata(rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_gnt(wr_gnt),
    .af_full(af_full), .af_addr_din(af_addr_din), .af_cmd_din(af_cmd_din), .af_wr_en(af_wr_en),
    .wdf_full(wdf_full), .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en),
    .rdf_valid(rdf_valid), .rdf_dout(rdf_dout),
    .err(err), .state_dbg(state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t state=%0d)", name, act, exp, $time, state_dbg);
    end
  endtask

  function automatic bit eligible(input int c);
    if (c == 2) return wr_req;
    if (m_tagq.size() >= TAG_DEPTH) return 0;
    return (c == 0) ? ic_req : dc_req;
  endfunction

  // Model update on each rising edge from the inputs present at that edge.
  always @(posedge clk) begin
    if (rst) begin
      m_who = -1; m_beat = 0; m_last = 2; m_beats = 0; m_err = 0;
      m_tagq.delete();
    end else begin
      int push_who;
      push_who = -1;
      if (m_who == -1) begin
        for (int i = 1; i <= 3; i++) begin
          int c;
          c = (m_last + i) % 3;
          if (eligible(c)) begin
            m_who = c; m_beat = 0;
            break;
          end
        end
      end else if (m_who < 2) begin
        if (!af_full) begin
          push_who = m_who; m_last = m_who; m_who = -1;
        end
      end else if (m_beat == 0) begin
        if (!af_full && !wdf_full) m_beat = 1;
      end else begin
        if (!wdf_full) begin
          m_last = 2; m_who = -1;
        end
      end
      if (rdf_valid) begin
        if (m_tagq.size() == 0) m_err = 1;
        else begin
          m_beats++;
          if (m_beats == 2) begin
            void'(m_tagq.pop_front());
            m_beats = 0;
          end
        end
      end
      if (push_who >= 0) m_tagq.push_back(push_who);
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    logic e_icg, e_dcg, e_wrg, e_icv, e_dcv, e_af, e_wdf, e_err;
    logic [2:0]   e_cmd;
    logic [30:0]  e_addr;
    logic [127:0] e_din;
    logic [15:0]  e_mask;
    e_icg = 0; e_dcg = 0; e_wrg = 0; e_icv = 0; e_dcv = 0;
    e_af = 0; e_wdf = 0; e_err = 0;
    e_cmd = 0; e_addr = 0; e_din = 0; e_mask = 0;
    if (!rst) begin
      if (m_who == 0 || m_who == 1) begin
        e_af   = !af_full;
        e_cmd  = 3'b001;
        e_addr = (m_who == 0) ? ic_addr : dc_addr;
        if (!af_full) begin
          if (m_who == 0) e_icg = 1; else e_dcg = 1;
        end
      end else if (m_who == 2 && m_beat == 0) begin
        e_af   = !af_full && !wdf_full;
        e_wdf  = e_af;
        e_cmd  = 3'b000;
        e_addr = wr_addr;
        e_din  = wr_data[255:128];
        e_mask = wr_mask[31:16];
      end else if (m_who == 2) begin
        e_wdf  = !wdf_full;
        e_wrg  = !wdf_full;
        e_din  = wr_data[127:0];
        e_mask = wr_mask[15:0];
      end
      if (rdf_valid && m_tagq.size() > 0) begin
        if (m_tagq[0] == 0) e_icv = 1; else e_dcv = 1;
      end
      e_err = m_err;
    end
    chk("ic_gnt", ic_gnt, e_icg);
    chk("dc_gnt", dc_gnt, e_dcg);
    chk("wr_gnt", wr_gnt, e_wrg);
    chk("ic_rvalid", ic_rvalid, e_icv);
    chk("dc_rvalid", dc_rvalid, e_dcv);
    chk("af_wr_en", af_wr_en, e_af);
    chk("wdf_wr_en", wdf_wr_en, e_wdf);
    chk("err", err, e_err);
    chk("rdata", rdata, rdf_dout);
    if (e_af) begin
      chk("af_cmd_din", af_cmd_din, e_cmd);
      chk("af_addr_din", af_addr_din, e_addr);
    end
    if (e_wdf) begin
      chk("wdf_din", wdf_din, e_din);
      chk("wdf_mask_din", wdf_mask_din, e_mask);
    end
    if (ic_gnt) glog.push_back(0);
    if (dc_gnt) glog.push_back(1);
    if (wr_gnt) glog.push_back(2);
    if (ic_rvalid) blog.push_back(0);
    if (dc_rvalid) blog.push_back(1);
  end

  // Driver tasks: all start and end just after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input int who, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((who == 0 && ic_gnt) || (who == 1 && dc_gnt) || (who == 2 && wr_gnt)) begin
        ok = 1;
        break;
      end
    end
    chk("gnt_within_budget", ok, 1'b1);
  endtask

  task automatic do_read(input int who, input logic [30:0] addr);
    if (who == 0) begin ic_addr = addr; ic_req = 1'b1; end
    else begin dc_addr = addr; dc_req = 1'b1; end
    wait_gnt(who, 40);
    tick();
    if (who == 0) ic_req = 1'b0; else dc_req = 1'b0;
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      rdf_valid = 1'b1;
      rdf_dout  = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    rdf_valid = 1'b0;
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ic_req = 0; dc_req = 0; wr_req = 0;
    ic_addr = 0; dc_addr = 0; wr_addr = 0;
    wr_data = '0; wr_mask = '0;
    af_full = 0; wdf_full = 0; rdf_valid = 0; rdf_dout = '0;
    tick();
    tick();
    chk("reset_ic_gnt", ic_gnt, 1'b0);
    chk("reset_af_wr_en", af_wr_en, 1'b0);
    chk("reset_err", err, 1'b0);
    rst = 1'b0;
    tick();

    // Single ic read at 0x100, then its two return beats.
    ic_addr = 31'h100; ic_req = 1'b1;
    @(negedge clk);
    chk("t1_idle_af", af_wr_en, 1'b0);
    @(negedge clk);
    chk("t1_af_wr_en", af_wr_en, 1'b1);
    chk("t1_cmd", af_cmd_din, 3'b001);
    chk("t1_addr", af_addr_din, 31'h100);
    chk("t1_ic_gnt", ic_gnt, 1'b1);
    tick();
    ic_req = 1'b0;
    rdf_valid = 1'b1; rdf_dout = 128'h55;
    @(negedge clk);
    chk("t1_beat0_ic", ic_rvalid, 1'b1);
    chk("t1_beat0_dc", dc_rvalid, 1'b0);
    tick();
    @(negedge clk);
    chk("t1_beat1_ic", ic_rvalid, 1'b1);
    tick();
    rdf_valid = 1'b0;
    tick();
    chk("t1_no_err", err, 1'b0);

    // All three requesting continuously: strict rotation ic, dc, wr.
    do_reset();
    glog.delete();
    ic_addr = 31'h1000; dc_addr = 31'h2000; wr_addr = 31'h3000;
    wr_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    wr_mask = $urandom;
    ic_req = 1; dc_req = 1; wr_req = 1;
    for (int i = 0; i < 80 && glog.size() < 6; i++) tick();
    ic_req = 0; dc_req = 0; wr_req = 0;
    chk("t2_grant_count", glog.size(), 6);
    begin
      int exp_g[6];
      exp_g = '{0, 1, 2, 0, 1, 2};
      for (int i = 0; i < 6 && i < glog.size(); i++) chk("t2_grant_order", glog[i], exp_g[i]);
    end
    blog.delete();
    beats(8);
    begin
      int exp_b[8];
      exp_b = '{0, 0, 1, 1, 0, 0, 1, 1};
      chk("t2_beat_count", blog.size(), 8);
      for (int i = 0; i < 8 && i < blog.size(); i++) chk("t2_beat_owner", blog[i], exp_b[i]);
    end

    // Write with wdf_full held for three cycles in the second beat.
    do_reset();
    glog.delete();
    wr_addr = 31'h0abc_0000; wr_data = {T3_HI, T3_LO}; wr_mask = 32'ha5a5_0f0f;
    wr_req = 1'b1;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (wdf_wr_en) begin seen = 1; break; end
      end
      chk("t3_wr1_seen", seen, 1'b1);
    end
    chk("t3_beat0_din", wdf_din, T3_HI);
    chk("t3_beat0_mask", wdf_mask_din, 16'ha5a5);
    chk("t3_beat0_cmd", af_cmd_din, 3'b000);
    tick();
    wdf_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stall_wdf_en", wdf_wr_en, 1'b0);
      chk("t3_stall_wr_gnt", wr_gnt, 1'b0);
      tick();
    end
    wdf_full = 1'b0;
    @(negedge clk);
    chk("t3_beat1_en", wdf_wr_en, 1'b1);
    chk("t3_beat1_din", wdf_din, T3_LO);
    chk("t3_beat1_mask", wdf_mask_din, 16'h0f0f);
    chk("t3_wr_gnt", wr_gnt, 1'b1);
    tick();
    wr_req = 1'b0;
    repeat (4) tick();
    chk("t3_wr_gnt_once", glog.size(), 1);

    // Four outstanding reads block a fifth until a read fully returns.
    do_reset();
    blog.delete();
    af_full = 1'b1; ic_addr = 31'h10; ic_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_af_stall", af_wr_en, 1'b0);
      tick();
    end
    af_full = 1'b0;
    wait_gnt(0, 10);
    tick();
    ic_req = 1'b0;
    do_read(1, 31'h20);
    do_read(1, 31'h30);
    do_read(0, 31'h40);
    ic_addr = 31'($urandom_range(32'h100, 32'hfff)); ic_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t4_blocked_gnt", ic_gnt, 1'b0);
      chk("t4_blocked_af", af_wr_en, 1'b0);
      tick();
    end
    beats(2);
    wait_gnt(0, 20);
    tick();
    ic_req = 1'b0;
    beats(8);
    begin
      int exp_b[10];
      exp_b = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
      chk("t4_beat_count", blog.size(), 10);
      for (int i = 0; i < 10 && i < blog.size(); i++) chk("t4_beat_owner", blog[i], exp_b[i]);
    end

    // Orphan read data sets a sticky error, also for data in flight over reset.
    do_reset();
    rdf_valid = 1'b1;
    @(negedge clk);
    chk("t5_no_ic_rvalid", ic_rvalid, 1'b0);
    chk("t5_no_dc_rvalid", dc_rvalid, 1'b0);
    tick();
    rdf_valid = 1'b0;
    @(negedge clk);
    chk("t5_err_set", err, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    chk("t5_err_sticky", err, 1'b1);
    tick();
    do_reset();
    @(negedge clk);
    chk("t5_err_cleared", err, 1'b0);
    tick();
    do_read(1, 31'h77);
    do_reset();
    rdf_valid = 1'b1;
    @(negedge clk);
    chk("t5_inflight_no_rvalid", dc_rvalid, 1'b0);
    tick();
    rdf_valid = 1'b0;
    @(negedge clk);
    chk("t5_inflight_err", err, 1'b1);
    tick();

    // Reset in WR1 drops enables at once; ic wins first afterwards.
    do_reset();
    wr_addr = 31'h5555; wr_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_wr1_af", af_wr_en, 1'b1);
    chk("t6_wr1_wdf", wdf_wr_en, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_af", af_wr_en, 1'b0);
    chk("t6_rst_wdf", wdf_wr_en, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    glog.delete();
    ic_addr = 31'h600; dc_addr = 31'h700; ic_req = 1'b1; dc_req = 1'b1;
    for (int i = 0; i < 40 && glog.size() < 3; i++) tick();
    ic_req = 0; dc_req = 0; wr_req = 0;
    chk("t6_grant_count", glog.size(), 3);
    begin
      int exp_g[3];
      exp_g = '{0, 1, 2};
      for (int i = 0; i < 3 && i < glog.size(); i++) chk("t6_grant_order", glog[i], exp_g[i]);
    end
    beats(4);
    repeat (2) tick();
    chk("t6_no_err", err, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
